fft_frame_sched: RTL and testbench

Frame scheduler that shares one 32-point streaming FFT core between two sample requesters. Round-robin arbitration between them, per-frame core reset, 32-sample input burst, collection of the 32-sample output burst tagged with the owning requester, and an optional latency watchdog. Sits between the two front-end sample sources and the FFT core, and is the only block that drives the core's `rst_n` and `in_valid`.

---
 rtl/fft_frame_sched.sv | 154 +++++++++++++++
 tb/tb_fft_frame_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// Round-robin frame scheduler sharing one streaming FFT core between two requesters.
// Define FFT_SCHED_TIMEOUT_EN to build the COLLECT latency watchdog.
module fft_frame_sched #(
  parameter int unsigned N         = 32,
  parameter int unsigned IN_W      = 12,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned LAT_LIMIT = 68
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic [IN_W-1:0]  s0_r,
  input  logic [IN_W-1:0]  s0_i,
  input  logic [IN_W-1:0]  s1_r,
  input  logic [IN_W-1:0]  s1_i,
  output logic             fft_rst_n,
  output logic             fft_in_valid,
  output logic [IN_W-1:0]  fft_din_r,
  output logic [IN_W-1:0]  fft_din_i,
  input  logic             fft_out_valid,
  input  logic [OUT_W-1:0] fft_dout_r,
  input  logic [OUT_W-1:0] fft_dout_i,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_r,
  output logic [OUT_W-1:0] out_i,
  output logic             out_tag,
  output logic             out_last,
  output logic             busy,
  output logic             err_timeout
);

  localparam int unsigned CNT_W = $clog2(N);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CRST    = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_FEED    = 3'd3;
  localparam logic [2:0] S_COLLECT = 3'd4;

  logic [2:0]       state, next_state;
  logic             sel, winner, last;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic             feed_done, frame_done, wd_fire;

  assign feed_done  = (state == S_FEED) && (in_cnt == CNT_W'(N-1));
  assign frame_done = (state == S_COLLECT) && fft_out_valid && (out_cnt == CNT_W'(N-1));

`ifdef FFT_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(LAT_LIMIT + 2);
  logic [WD_W-1:0] wd_cnt;

  // A completing sample in the same cycle as the limit wins over the watchdog.
  assign wd_fire = (state == S_COLLECT) && !frame_done && (wd_cnt == WD_W'(LAT_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt      <= (state == S_COLLECT) ? wd_cnt + WD_W'(1) : '0;
      err_timeout <= wd_fire;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next state and arbitration; req is only looked at in IDLE.
  always_comb begin
    next_state = state;
    winner     = sel;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          next_state = S_CRST;
          winner     = (req0 && req1) ? ~last : req1;
        end
      end
      S_CRST:    next_state = S_GAP;
      S_GAP:     next_state = S_FEED;
      S_FEED:    if (feed_done) next_state = S_COLLECT;
      S_COLLECT: if (frame_done || wd_fire) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Control outputs are decoded from next_state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= 1'b0;
      last      <= 1'b1;
      in_cnt    <= '0;
      out_cnt   <= '0;
      fft_rst_n <= 1'b0;
      busy      <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
    end else begin
      sel       <= winner;
      if (feed_done) last <= sel;
      in_cnt    <= (state == S_FEED && !feed_done) ? in_cnt + CNT_W'(1) : '0;
      if (state != S_COLLECT)  out_cnt <= '0;
      else if (fft_out_valid)  out_cnt <= out_cnt + CNT_W'(1);
      fft_rst_n <= (next_state != S_CRST);
      busy      <= (next_state != S_IDLE);
      gnt0      <= (next_state == S_FEED) && !sel;
      gnt1      <= (next_state == S_FEED) && sel;
    end
  end

  // Input path: the sample taken while gnt is high is presented to the core one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fft_in_valid <= 1'b0;
      fft_din_r    <= '0;
      fft_din_i    <= '0;
    end else begin
      fft_in_valid <= (state == S_FEED);
      if (state == S_FEED) begin
        fft_din_r <= sel ? s1_r : s0_r;
        fft_din_i <= sel ? s1_i : s0_i;
      end
    end
  end

  // Result path: core outputs are only accepted while collecting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_tag   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= (state == S_COLLECT) && fft_out_valid;
      out_last  <= frame_done;
      if (state == S_COLLECT && fft_out_valid) begin
        out_r   <= fft_dout_r;
        out_i   <= fft_dout_i;
        out_tag <= sel;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed self-checking bench for fft_frame_sched; the FFT core is emulated by driving fft_out_* directly.
// Timeout checks are only built when FFT_SCHED_TIMEOUT_EN is defined.
module tb_fft_frame_sched;
  localparam int unsigned N     = 32;
  localparam int unsigned IN_W  = 12;
  localparam int unsigned OUT_W = 16;

  logic clk, rst, req0, req1, gnt0, gnt1;
  logic [IN_W-1:0]  s0_r, s0_i, s1_r, s1_i, fft_din_r, fft_din_i;
  logic fft_rst_n, fft_in_valid, fft_out_valid;
  logic [OUT_W-1:0] fft_dout_r, fft_dout_i, out_r, out_i;
  logic out_valid, out_tag, out_last, busy, err_timeout;

  int tests = 0;
  int fails = 0;

  fft_frame_sched #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .LAT_LIMIT(68)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .s0_r(s0_r), .s0_i(s0_i), .s1_r(s1_r), .s1_i(s1_i),
    .fft_rst_n(fft_rst_n), .fft_in_valid(fft_in_valid),
    .fft_din_r(fft_din_r), .fft_din_i(fft_din_i),
    .fft_out_valid(fft_out_valid), .fft_dout_r(fft_dout_r), .fft_dout_i(fft_dout_i),
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i), .out_tag(out_tag),
    .out_last(out_last), .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] samp_r(input int who, input int i);
    return IN_W'(who * 64 + i + 1);
  endfunction
  function automatic logic [IN_W-1:0] samp_i(input int who, input int i);
    return IN_W'(-(who * 64 + i + 1));
  endfunction
  function automatic logic [OUT_W-1:0] res_r(input int fid, input int k);
    return OUT_W'(fid * 256 + k * 3);
  endfunction
  function automatic logic [OUT_W-1:0] res_i(input int fid, input int k);
    return OUT_W'(-(fid * 100 + k + 1));
  endfunction

  // Caller raises req in an IDLE cycle; mode 0 holds req, 1 drops it in CRST, 2 also toggles req1 during FEED.
  task automatic do_frame(input int who, input int gap_after, input int n_out, input int fid, input int mode);
    @(negedge clk);
    check("crst_rst_n", fft_rst_n, 0);
    check("crst_busy", busy, 1);
    if (mode != 0) begin req0 = 1'b0; req1 = 1'b0; end
    fft_out_valid = 1'b1;
    fft_dout_r = 16'h7fff;
    @(negedge clk);
    check("gap_rst_n", fft_rst_n, 1);
    check("gap_gnt", {gnt1, gnt0}, 0);
    fft_out_valid = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      check("feed_gnt", {gnt1, gnt0}, (who != 0) ? 2 : 1);
      check("feed_in_valid", fft_in_valid, (i > 0) ? 1 : 0);
      if (i == 0) check("ignored_out_valid", out_valid, 0);
      if (i > 0) begin
        check("feed_din_r", fft_din_r, samp_r(who, i - 1));
        check("feed_din_i", fft_din_i, samp_i(who, i - 1));
      end
      if (mode == 2 && i == 5)  req1 = 1'b1;
      if (mode == 2 && i == 20) req1 = 1'b0;
      s0_r = samp_r(0, i); s0_i = samp_i(0, i);
      s1_r = samp_r(1, i); s1_i = samp_i(1, i);
    end
    @(negedge clk);
    check("post_feed_gnt", {gnt1, gnt0}, 0);
    check("last_in_valid", fft_in_valid, 1);
    check("last_din_r", fft_din_r, samp_r(who, N - 1));
    @(negedge clk);
    check("in_valid_end", fft_in_valid, 0);
    repeat (18) @(negedge clk);
    check("no_early_out", out_valid, 0);
    for (int k = 0; k < n_out; k++) begin
      if (gap_after >= 0 && k == gap_after + 1) begin
        fft_out_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          check("gap_out_valid", out_valid, 0);
        end
      end
      fft_out_valid = 1'b1;
      fft_dout_r = res_r(fid, k);
      fft_dout_i = res_i(fid, k);
      @(negedge clk);
      check("out_valid", out_valid, 1);
      check("out_r", out_r, res_r(fid, k));
      check("out_i", out_i, res_i(fid, k));
      check("out_tag", out_tag, who);
      check("out_last", out_last, (k == int'(N) - 1) ? 1 : 0);
      check("no_err", err_timeout, 0);
    end
    fft_out_valid = 1'b0;
  endtask

  initial begin
    int seen;
    int at_c;
    int last_cnt;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    s0_r = '0; s0_i = '0; s1_r = '0; s1_i = '0;
    fft_out_valid = 1'b0; fft_dout_r = '0; fft_dout_i = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rst_n", fft_rst_n, 0);
    check("rst_gnt", {gnt1, gnt0}, 0);
    check("rst_in_valid", fft_in_valid, 0);
    check("rst_out", {out_valid, out_last, out_tag, busy, err_timeout}, 0);
    check("rst_din", {fft_din_r, fft_din_i}, 0);
    check("rst_out_data", {out_r, out_i}, 0);
    rst = 1'b0;
    #1 check("rel_rst_n_hold", fft_rst_n, 0);
    @(negedge clk);
    check("rel_rst_n", fft_rst_n, 1);
    check("rel_busy", busy, 0);

    // Contention: 0,1,0,1
    req0 = 1'b1; req1 = 1'b1;
    do_frame(0, -1, N, 1, 0);
    do_frame(1, -1, N, 2, 0);
    do_frame(0, -1, N, 3, 0);
    do_frame(1, -1, N, 4, 1);
    @(negedge clk);
    check("idle_after_rr", busy, 0);

    // Single requester 0 with a req1 raised and withdrawn while busy
    req0 = 1'b1;
    do_frame(0, -1, N, 5, 2);
    repeat (3) begin
      @(negedge clk);
      check("withdrawn_req1", {busy, gnt1}, 0);
    end

    // Output gap after sample 10
    req0 = 1'b1;
    do_frame(0, 10, N, 6, 1);
    @(negedge clk);
    check("gap_frame_idle", busy, 0);

`ifdef FFT_SCHED_TIMEOUT_EN
    // Watchdog: 31 outputs then silence
    req1 = 1'b1;
    do_frame(1, -1, N - 1, 7, 1);
    seen = 0; at_c = -1; last_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (err_timeout) begin seen++; if (at_c < 0) at_c = c; end
      if (out_last) last_cnt++;
    end
    check("wd_pulses", seen, 1);
    check("wd_cycle", at_c, 18);
    check("wd_no_last", last_cnt, 0);
    check("wd_idle", busy, 0);
    req0 = 1'b1;
    do_frame(0, -1, N, 8, 1);
    @(negedge clk);
`endif

    // Reset in FEED cycle 15 of a requester-1 frame
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) @(negedge clk);
    check("pre_abort_gnt1", gnt1, 1);
    rst = 1'b1;
    #1;
    check("abort_gnt", {gnt1, gnt0}, 0);
    check("abort_state", {busy, fft_in_valid, out_valid, fft_rst_n}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle", {busy, out_valid, out_last, err_timeout}, 0);
    check("abort_rst_n", fft_rst_n, 1);
    req0 = 1'b1; req1 = 1'b1;
    do_frame(0, -1, N, 9, 1);
    @(negedge clk);
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
